// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the opcodes the ALU recognises.
package alu_pkg;

  localparam int XLEN = 32;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 3'b000;
  localparam alu_op_t ALU_SUB = 3'b100;
  localparam alu_op_t ALU_AND = 3'b111;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle for the two ports sharing the ALU.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic            req0_valid;
  logic            req0_ready;
  alu_op_t         req0_opcode;
  logic [XLEN-1:0] req0_left;
  logic [XLEN-1:0] req0_right;
  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [XLEN-1:0] rsp0_result;

  logic            req1_valid;
  logic            req1_ready;
  alu_op_t         req1_opcode;
  logic [XLEN-1:0] req1_left;
  logic [XLEN-1:0] req1_right;
  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [XLEN-1:0] rsp1_result;

  modport master (
    output req0_valid, req0_opcode, req0_left, req0_right, rsp0_ready,
    output req1_valid, req1_opcode, req1_left, req1_right, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_result,
    input  req1_ready, rsp1_valid, rsp1_result
  );

  modport slave (
    input  req0_valid, req0_opcode, req0_left, req0_right, rsp0_ready,
    input  req1_valid, req1_opcode, req1_left, req1_right, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_result,
    output req1_ready, rsp1_valid, rsp1_result
  );

endinterface

// File: rtl/alu.sv
// Combinational ALU; modulo-2^XLEN arithmetic, no flags. Unknown opcodes yield 0.
module alu
  import alu_pkg::*;
(
  input  alu_op_t         opcode,
  input  logic [XLEN-1:0] left,
  input  logic [XLEN-1:0] right,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD: result = left + right;
      ALU_SUB: result = left - right;
      ALU_AND: result = left & right;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters with one-entry response slots.
// Optional grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import alu_pkg::*;
#(
`ifdef ALU_ARB_STATS_EN
  parameter int CNT_W = 16,
`endif
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic           clk,
  input  logic           rst,
  alu_arbiter_if.slave   bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant0_count,
  output logic [CNT_W-1:0] grant1_count
`endif
);

  logic            elig0, elig1;
  logic            grant0, grant1;
  logic            last_grant_p1;
  logic            full0_p1, full1_p1;
  logic [XLEN-1:0] result0_p1, result1_p1;
  alu_op_t         alu_op_p0;
  logic [XLEN-1:0] alu_left_p0, alu_right_p0, alu_result_p0;

  // Stage p0: eligibility (a full slot being drained this cycle can refill) and pick
  always_comb begin
    elig0  = bus.req0_valid && (!full0_p1 || bus.rsp0_ready);
    elig1  = bus.req1_valid && (!full1_p1 || bus.rsp1_ready);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        grant0 = last_grant_p1;
        grant1 = !last_grant_p1;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  always_comb begin
    alu_op_p0    = grant1 ? bus.req1_opcode : bus.req0_opcode;
    alu_left_p0  = grant1 ? bus.req1_left   : bus.req0_left;
    alu_right_p0 = grant1 ? bus.req1_right  : bus.req0_right;
  end

  alu u_alu (
    .opcode (alu_op_p0),
    .left   (alu_left_p0),
    .right  (alu_right_p0),
    .result (alu_result_p0)
  );

  // Stage p1: response slots; results are cleared on reset so outputs read zero
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_p1 <= (RESET_PRIO == 0) ? 1'b1 : 1'b0;
      full0_p1      <= 1'b0;
      full1_p1      <= 1'b0;
      result0_p1    <= '0;
      result1_p1    <= '0;
    end else begin
      if (grant0 || grant1) last_grant_p1 <= grant1;
      if (grant0) begin
        full0_p1   <= 1'b1;
        result0_p1 <= alu_result_p0;
      end else if (bus.rsp0_ready) begin
        full0_p1   <= 1'b0;
      end
      if (grant1) begin
        full1_p1   <= 1'b1;
        result1_p1 <= alu_result_p0;
      end else if (bus.rsp1_ready) begin
        full1_p1   <= 1'b0;
      end
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.rsp0_valid  = full0_p1;
  assign bus.rsp1_valid  = full1_p1;
  assign bus.rsp0_result = result0_p1;
  assign bus.rsp1_result = result1_p1;

`ifdef ALU_ARB_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      grant0_count <= '0;
      grant1_count <= '0;
    end else begin
      if (grant0) grant0_count <= sat_inc(grant0_count);
      if (grant1) grant1_count <= sat_inc(grant1_count);
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter (RESET_PRIO = 0; CNT_W = 2 when stats are built).
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_arbiter_if bus ();

`ifdef ALU_ARB_STATS_EN
  localparam int CNT_W = 2;
  logic [CNT_W-1:0] g0_cnt, g1_cnt;

  alu_arbiter #(.CNT_W(CNT_W), .RESET_PRIO(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .grant0_count (g0_cnt),
    .grant1_count (g1_cnt)
  );
`else
  alu_arbiter #(.RESET_PRIO(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  typedef struct {
    logic        v0;
    alu_op_t     op0;
    logic [31:0] l0, r0;
    logic        rr0;
    logic        v1;
    alu_op_t     op1;
    logic [31:0] l1, r1;
    logic        rr1;
    logic        e_rdy0, e_rdy1;
    logic        e_rv0;
    logic [31:0] e_res0;
    logic        e_rv1;
    logic [31:0] e_res1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic v0, alu_op_t op0, logic [31:0] l0, logic [31:0] r0, logic rr0,
                               logic v1, alu_op_t op1, logic [31:0] l1, logic [31:0] r1, logic rr1,
                               logic e_rdy0, logic e_rdy1, logic e_rv0, logic [31:0] e_res0,
                               logic e_rv1, logic [31:0] e_res1);
    vec_t v;
    v.v0 = v0; v.op0 = op0; v.l0 = l0; v.r0 = r0; v.rr0 = rr0;
    v.v1 = v1; v.op1 = op1; v.l1 = l1; v.r1 = r1; v.rr1 = rr1;
    v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1;
    v.e_rv0 = e_rv0; v.e_res0 = e_res0; v.e_rv1 = e_rv1; v.e_res1 = e_res1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.req0_valid  = v.v0;
    bus.req0_opcode = v.op0;
    bus.req0_left   = v.l0;
    bus.req0_right  = v.r0;
    bus.rsp0_ready  = v.rr0;
    bus.req1_valid  = v.v1;
    bus.req1_opcode = v.op1;
    bus.req1_left   = v.l1;
    bus.req1_right  = v.r1;
    bus.rsp1_ready  = v.rr1;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input int i, input vec_t v);
    apply(v);
    #1;
    chk($sformatf("v%0d req0_ready", i), {31'd0, bus.req0_ready}, {31'd0, v.e_rdy0});
    chk($sformatf("v%0d req1_ready", i), {31'd0, bus.req1_ready}, {31'd0, v.e_rdy1});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d rsp0_valid", i), {31'd0, bus.rsp0_valid}, {31'd0, v.e_rv0});
    chk($sformatf("v%0d rsp1_valid", i), {31'd0, bus.rsp1_valid}, {31'd0, v.e_rv1});
    if (v.e_rv0) chk($sformatf("v%0d rsp0_result", i), bus.rsp0_result, v.e_res0);
    if (v.e_rv1) chk($sformatf("v%0d rsp1_result", i), bus.rsp1_result, v.e_res1);
    @(negedge clk);
  endtask

  initial begin
    //          v0 op0     l0     r0     rr0 v1 op1     l1     r1     rr1  rdy0 rdy1 rv0 res0          rv1 res1
    tbl.push_back(mkv(1, ALU_ADD, 32'd4, 32'd3, 1, 1, ALU_AND, 32'hC, 32'hA, 1,  1, 0, 1, 32'd7,        0, 32'd0));
    tbl.push_back(mkv(0, ALU_ADD, 32'd0, 32'd0, 1, 1, ALU_AND, 32'hC, 32'hA, 1,  0, 1, 0, 32'd0,        1, 32'h8));
    tbl.push_back(mkv(0, ALU_ADD, 32'd0, 32'd0, 1, 0, ALU_ADD, 32'd0, 32'd0, 1,  0, 0, 0, 32'd0,        0, 32'd0));
    tbl.push_back(mkv(1, ALU_ADD, 32'd4, 32'd3, 1, 0, ALU_ADD, 32'd0, 32'd0, 1,  1, 0, 1, 32'd7,        0, 32'd0));
    tbl.push_back(mkv(1, ALU_SUB, 32'd3, 32'd7, 1, 0, ALU_ADD, 32'd0, 32'd0, 1,  1, 0, 1, 32'hFFFFFFFC, 0, 32'd0));
    tbl.push_back(mkv(1, ALU_ADD, 32'd1, 32'd1, 1, 1, ALU_ADD, 32'd10, 32'd10, 1, 0, 1, 0, 32'd0,       1, 32'd20));
    tbl.push_back(mkv(1, ALU_ADD, 32'd2, 32'd2, 1, 1, ALU_ADD, 32'd11, 32'd11, 1, 1, 0, 1, 32'd4,       0, 32'd0));
    tbl.push_back(mkv(1, ALU_ADD, 32'd3, 32'd3, 1, 1, ALU_ADD, 32'd12, 32'd12, 1, 0, 1, 0, 32'd0,       1, 32'd24));
    tbl.push_back(mkv(1, ALU_ADD, 32'd5, 32'd5, 1, 1, ALU_ADD, 32'd13, 32'd13, 1, 1, 0, 1, 32'd10,      0, 32'd0));
    tbl.push_back(mkv(1, ALU_ADD, 32'd6, 32'd6, 1, 1, ALU_ADD, 32'd14, 32'd14, 1, 0, 1, 0, 32'd0,       1, 32'd28));
    tbl.push_back(mkv(1, ALU_ADD, 32'd7, 32'd7, 1, 1, ALU_ADD, 32'd15, 32'd15, 1, 1, 0, 1, 32'd14,      0, 32'd0));
    tbl.push_back(mkv(0, ALU_ADD, 32'd0, 32'd0, 1, 1, ALU_SUB, 32'd7, 32'd3, 1,  0, 1, 0, 32'd0,        1, 32'd4));
    tbl.push_back(mkv(1, ALU_ADD, 32'd1, 32'd2, 1, 1, ALU_SUB, 32'd9, 32'd1, 0,  1, 0, 1, 32'd3,        1, 32'd4));
    tbl.push_back(mkv(1, ALU_ADD, 32'd2, 32'd2, 1, 1, ALU_SUB, 32'd9, 32'd1, 0,  1, 0, 1, 32'd4,        1, 32'd4));
    tbl.push_back(mkv(1, ALU_ADD, 32'd3, 32'd3, 1, 1, ALU_SUB, 32'd9, 32'd1, 0,  1, 0, 1, 32'd6,        1, 32'd4));
    tbl.push_back(mkv(1, ALU_ADD, 32'd4, 32'd4, 1, 1, ALU_SUB, 32'd9, 32'd1, 1,  0, 1, 0, 32'd0,        1, 32'd8));
    tbl.push_back(mkv(0, ALU_ADD, 32'd0, 32'd0, 1, 0, ALU_ADD, 32'd0, 32'd0, 1,  0, 0, 0, 32'd0,        0, 32'd0));

    // Reset with both requesters asserting valid
    apply(mkv(1, ALU_ADD, 32'd1, 32'd1, 0, 1, ALU_ADD, 32'd2, 32'd2, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req0_ready", {31'd0, bus.req0_ready}, 32'd0);
    chk("rst req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    chk("rst rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    chk("rst rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    chk("rst rsp0_result", bus.rsp0_result, 32'd0);
    chk("rst rsp1_result", bus.rsp1_result, 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("rst grant0_count", {30'd0, g0_cnt}, 32'd0);
    chk("rst grant1_count", {30'd0, g1_cnt}, 32'd0);
`endif
    rst = 1'b0;

    foreach (tbl[i]) step(i, tbl[i]);

    // Reset the cycle after an accept: the slot must be discarded
    apply(mkv(1, ALU_ADD, 32'd5, 32'd5, 0, 0, ALU_ADD, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("mid accept req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("mid rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
    chk("mid rsp0_result", bus.rsp0_result, 32'd10);
    @(negedge clk);
    rst = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("mid rst req0_ready", {31'd0, bus.req0_ready}, 32'd0);
    chk("mid rst req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("mid rst rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    chk("mid rst rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    chk("mid rst rsp0_result", bus.rsp0_result, 32'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post rst rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    chk("post rst rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("post rst grant0_count", {30'd0, g0_cnt}, 32'd0);
`endif
    @(negedge clk);

    // Five back-to-back port 0 grants (counter saturation when stats are built)
    for (int k = 0; k < 5; k++) begin
      apply(mkv(1, ALU_ADD, k, 32'd1, 1, 0, ALU_ADD, 32'd0, 32'd0, 1, 0, 0, 0, 0, 0, 0));
      #1;
      chk($sformatf("burst%0d req0_ready", k), {31'd0, bus.req0_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("burst%0d rsp0_result", k), bus.rsp0_result, k + 1);
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
`ifdef ALU_ARB_STATS_EN
    chk("sat grant0_count", {30'd0, g0_cnt}, 32'd3);
    chk("sat grant1_count", {30'd0, g1_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;
    chk("burst drain rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between two requesters: port 0 (fetch/PC-increment path) and port 1 (execute stage). Arbitration is round-robin. The block registers the ALU result into a per-port response slot with a valid/ready handshake. The block sits between the core's front end and the single ALU, so both stages can issue operations without duplicating the adder.

## Interface
Parameters:
- `CNT_W`, default 16: width of the grant counters. Only present with the stats macro defined.
- `RESET_PRIO`, default 0: the port that wins the first contended cycle after reset. Must be 0 or 1.

Ports:
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset. Sampled on the `clk` rising edge.
- `req0_valid` in 1: port 0 has an operation.
- `req0_ready` out 1: port 0 operation accepted this cycle.
- `req0_opcode` in 3: ALU opcode.
- `req0_left` in 32 and `req0_right` in 32: operands.
- `rsp0_valid` out 1: port 0 result available.
- `rsp0_ready` in 1: port 0 consumer takes the result.
- `rsp0_result` out 32: port 0 result.
- `req1_*` and `rsp1_*`: identical to port 0.
- `grant0_count` out `CNT_W` and `grant1_count` out `CNT_W`: accepted-operation counters. Present only with the stats macro defined.

## Operation
- Each port has a one-entry response slot, either EMPTY or FULL. `rspN_valid` is 1 exactly when slot N is FULL.
- Port N is eligible in a cycle when both hold:
  - `reqN_valid` = 1.
  - Slot N is EMPTY, or (`rspN_valid` && `rspN_ready`) this cycle. The second case lets the slot drain and refill in the same cycle.
- Grant rule:
  - Only one port eligible: that port is granted.
  - Both eligible: the port that is not `last_grant` is granted.
  - `last_grant` updates to the granted port on every grant.
  - Reset sets `last_grant` to the port that is not `RESET_PRIO`.
- `reqN_ready` is 1 exactly when port N is granted.
  - `reqN_ready` may depend combinationally on `req*_valid` and `rsp*_ready`.
  - Requesters must not derive `valid` from `ready`.
- The granted port's opcode and operands are muxed into the `alu`. The ALU output is written into that port's slot, which goes FULL.
- Opcodes are passed through uninterpreted. Defined opcodes are `000` ADD, `100` SUB and `111` AND. Arithmetic is modulo 2^32 with no flags.
- A FULL slot holds its result stable until `rspN_ready`.
  - If the slot is drained with no refill, it goes EMPTY.
  - If it is drained and refilled in the same cycle, it stays FULL and carries the new result.
- When no port is granted, ALU operands are don't-care. The ALU drives no state in that case.

## Timing
- Reset values:
  - `rsp0_valid` and `rsp1_valid` = 0.
  - `rsp0_result` and `rsp1_result` = 0.
  - `req*_ready` = 0 while `rst` is high.
  - Counters = 0.
- Latency: an operation accepted at edge N has `rspN_valid` = 1 and its result valid in the cycle after edge N.
- Throughput: one operation per cycle in total, shared between the ports. A single uncontended port with `rsp_ready` tied high gets one operation per cycle.
- Backpressure: if a slot is FULL and its `rsp_ready` = 0, that port's `req_ready` = 0. The other port is unaffected.
- Reset asserted mid-operation: in-flight results are discarded and the slots go EMPTY on that edge. No response is emitted for requests accepted before reset.

## Configuration
- `ALU_ARB_STATS_EN`:
  - Defined: the `grant0_count` and `grant1_count` ports exist. Each increments by 1 on every accepted operation of its port and saturates at 2^`CNT_W` − 1.
  - Undefined: the ports and counters are absent. Arbitration behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams `ALU_ADD` = 3'b000, `ALU_SUB` = 3'b100, `ALU_AND` = 3'b111.
  - `XLEN` = 32.
- One sub-module: the existing `alu`, instantiated once.
- Round-robin pick, response slots and counters are inline.

## Test plan
- Port 0 only, ADD, left = 4, right = 3: `req0_ready` = 1, next cycle `rsp0_valid` = 1 with `rsp0_result` = 7. Port 1 sees no activity.
- Both ports request in the first cycle after reset with `RESET_PRIO` = 0:
  - Port 0: ADD 4, 3. Port 1: AND 0xC, 0xA.
  - Port 0 is granted first, then port 1 on the next cycle.
  - `rsp0_result` = 7, `rsp1_result` = 0x8.
- Both ports held valid for 6 cycles with `rsp_ready` high: grants alternate 0,1,0,1,0,1.
- `rsp1_ready` held 0 after a port 1 SUB 7, 3:
  - `rsp1_result` = 4 is held and `req1_ready` stays 0.
  - Port 0 keeps getting one grant per cycle.
  - Raising `rsp1_ready` gives drain and refill in the same cycle.
- Port 0 SUB 3, 7 gives 0xFFFFFFFC (wraps).
- Reset asserted the cycle after an accept: no response appears and outputs return to reset values.
- With `ALU_ARB_STATS_EN` defined and `CNT_W` = 2: 5 port 0 grants leave `grant0_count` = 3 (saturated) and `grant1_count` = 0.
